enemy_spawn_scheduler: RTL and testbench

ENEMY_SPAWN_SCHEDULER -- requirements
Module: enemy_spawn_scheduler

---
 rtl/enemy_spawn_scheduler_pkg.sv | 26 ++
 rtl/enemy_spawn_scheduler_if.sv | 29 ++
 rtl/enemy_spawn_scheduler_rr_slot_picker.sv | 45 ++++
 rtl/enemy_spawn_scheduler.sv | 169 ++++++++++++++++
 tb/tb_enemy_spawn_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared definitions for the enemy spawn scheduler: FSM state encodings,
// default slot count, spawn-type LFSR seed, settle duration and the LFSR
// step function.
package enemy_spawn_scheduler_pkg;

    localparam int         NUM_SLOTS_DEF = 4;
    localparam logic [3:0] LFSR_SEED_DEF = 4'b1001;
    localparam int         SETTLE_CYCLES = 3;

    // Settle counter loads this value and counts down to zero.
    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    // One-hot so an illegal state (no bit or several bits set) is trivially detectable.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_COUNT  = 4'b0010,
        ST_GRANT  = 4'b0100,
        ST_SETTLE = 4'b1000
    } state_e;

    // Spawn-type LFSR step: shift left, feed back q[3]^q[2].
    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Game-side bus of the enemy spawn scheduler.
//   master : game/testbench side, drives enable, tick, spawnPeriod, slotDead
//   slave  : scheduler side, drives canSpawn, spawnType, damageSCEN,
//            moveSCEN, activeCount
interface enemy_spawn_scheduler_if
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF
);
    logic                 enable;
    logic                 tick;
    logic [7:0]           spawnPeriod;
    logic [NUM_SLOTS-1:0] slotDead;
    logic [NUM_SLOTS-1:0] canSpawn;
    logic [1:0]           spawnType;
    logic                 damageSCEN;
    logic                 moveSCEN;
    logic [2:0]           activeCount;

    modport master (
        output enable, tick, spawnPeriod, slotDead,
        input  canSpawn, spawnType, damageSCEN, moveSCEN, activeCount
    );

    modport slave (
        input  enable, tick, spawnPeriod, slotDead,
        output canSpawn, spawnType, damageSCEN, moveSCEN, activeCount
    );
endinterface

// File: rtl/enemy_spawn_scheduler_rr_slot_picker.sv
// Round-robin free-slot picker (purely combinational).
//   freeMask : slots eligible for a spawn
//   rrPtr    : slot where the search starts
//   sel      : first eligible slot at or above rrPtr, wrapping past the top
//   anyFree  : at least one slot is eligible (sel is meaningless otherwise)
module rr_slot_picker
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter  int NUM_SLOTS = NUM_SLOTS_DEF,
    localparam int PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [NUM_SLOTS-1:0] freeMask,
    input  logic [PTR_W-1:0]     rrPtr,
    output logic [PTR_W-1:0]     sel,
    output logic                 anyFree
);

    // Slot index at distance off above base, modulo NUM_SLOTS.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SLOTS) begin
            sum = sum - NUM_SLOTS;
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest free slot wins last.
    always_comb begin
        sel     = '0;
        anyFree = 1'b0;
        for (int off = NUM_SLOTS - 1; off >= 0; off--) begin
            if (freeMask[wrap_idx(rrPtr, off)]) begin
                sel     = wrap_idx(rrPtr, off);
                anyFree = 1'b1;
            end else begin
                sel     = sel;
                anyFree = anyFree;
            end
        end
    end

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: every spawnPeriod game ticks grants one dead enemy
// slot a one-cycle spawn (canSpawn, one-hot) with an LFSR-chosen spawnType,
// then waits a fixed settle time for the unit to deploy. Independently it
// turns each tick into a damage-phase pulse and, one cycle later, a
// move-phase pulse, and reports how many slots are alive.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : game-side signals (see enemy_spawn_scheduler_if, slave side)
// All outputs come straight from flops.
module enemy_spawn_scheduler
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter int         NUM_SLOTS = NUM_SLOTS_DEF,
    parameter logic [3:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    enemy_spawn_scheduler_if.slave  bus
);

    localparam int               PTR_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

    state_e               state_q,       state_d;
    logic [7:0]           cnt_q,         cnt_d;
    logic [1:0]           settle_cnt_q,  settle_cnt_d;
    logic [PTR_W-1:0]     rr_ptr_q,      rr_ptr_d;
    logic [3:0]           lfsr_q,        lfsr_d;
    logic [NUM_SLOTS-1:0] settle_mask_q, settle_mask_d;
    logic [NUM_SLOTS-1:0] can_spawn_q,   can_spawn_d;
    logic [1:0]           spawn_type_q,  spawn_type_d;
    logic                 damage_q,      damage_d;
    logic                 move_q,        move_d;
    logic [2:0]           active_cnt_q,  active_cnt_d;

    logic [NUM_SLOTS-1:0] free_mask_s;
    logic [NUM_SLOTS-1:0] sel_onehot_s;
    logic [PTR_W-1:0]     sel_s;
    logic                 any_free_s;
    logic [7:0]           period_s;

    // The slot granted in this spawn round stays excluded until the round's settle ends.
    assign free_mask_s  = bus.slotDead & ~settle_mask_q;
    assign sel_onehot_s = NUM_SLOTS'(1'b1) << sel_s;
    assign period_s     = (bus.spawnPeriod == 8'd0) ? 8'd1 : bus.spawnPeriod;

    rr_slot_picker #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_picker (
        .freeMask (free_mask_s),
        .rrPtr    (rr_ptr_q),
        .sel      (sel_s),
        .anyFree  (any_free_s)
    );

    // Spawn FSM next state; grant outputs are prepared here so they appear registered in GRANT.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        settle_cnt_d  = settle_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        lfsr_d        = lfsr_q;
        settle_mask_d = settle_mask_q;
        can_spawn_d   = '0;
        spawn_type_d  = spawn_type_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_COUNT;
                    cnt_d   = period_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 8'd0) begin
                    if (bus.tick) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (any_free_s) begin
                    // Period expired: grant now; with no free slot we simply wait here at 0.
                    state_d       = ST_GRANT;
                    can_spawn_d   = sel_onehot_s;
                    spawn_type_d  = lfsr_q[1:0];
                    settle_mask_d = sel_onehot_s;
                    if (sel_s == LAST_SLOT) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = sel_s + PTR_W'(1);
                    end
                end else begin
                    state_d = ST_COUNT;
                end
            end
            ST_GRANT: begin
                // Type was consumed on entry to GRANT, so the LFSR steps now.
                state_d      = ST_SETTLE;
                settle_cnt_d = SETTLE_LAST;
                lfsr_d       = lfsr_next(lfsr_q);
            end
            ST_SETTLE: begin
                if (!bus.enable) begin
                    state_d       = ST_IDLE;
                    settle_mask_d = '0;
                end else if (settle_cnt_q == 2'd0) begin
                    state_d       = ST_COUNT;
                    cnt_d         = period_s;
                    settle_mask_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                settle_mask_d = '0;
            end
        endcase
    end

    // Phase pulses and alive count, independent of the spawn FSM.
    always_comb begin
        damage_d     = bus.enable & bus.tick;
        move_d       = damage_q;
        active_cnt_d = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active_cnt_d = active_cnt_d + {2'b00, ~bus.slotDead[i]};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            settle_cnt_q  <= 2'd0;
            rr_ptr_q      <= '0;
            lfsr_q        <= LFSR_SEED;
            settle_mask_q <= '0;
            can_spawn_q   <= '0;
            spawn_type_q  <= 2'b00;
            damage_q      <= 1'b0;
            move_q        <= 1'b0;
            active_cnt_q  <= 3'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            lfsr_q        <= lfsr_d;
            settle_mask_q <= settle_mask_d;
            can_spawn_q   <= can_spawn_d;
            spawn_type_q  <= spawn_type_d;
            damage_q      <= damage_d;
            move_q        <= move_d;
            active_cnt_q  <= active_cnt_d;
        end
    end

    assign bus.canSpawn    = can_spawn_q;
    assign bus.spawnType   = spawn_type_q;
    assign bus.damageSCEN  = damage_q;
    assign bus.moveSCEN    = move_q;
    assign bus.activeCount = active_cnt_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Scoreboard bench for enemy_spawn_scheduler: stimulus pushes expected grants
// and phase pulses (with the cycle they must appear in); a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_enemy_spawn_scheduler;

    localparam int NS = 4;

    typedef struct packed {
        logic [3:0]  mask;
        logic [1:0]  typ;
        logic [31:0] at;
    } grant_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;

    grant_t grant_q[$];
    int     dmg_q[$];
    int     mv_q[$];
    grant_t mon_g;
    int     mon_c;

    enemy_spawn_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    enemy_spawn_scheduler #(
        .NUM_SLOTS (NS),
        .LFSR_SEED (4'b1001)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each tick with enable high must give damage next cycle and move the one after.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            if (bus.enable) begin
                dmg_q.push_back(cyc + 1);
                mv_q.push_back(cyc + 2);
            end
            step(1);
        end
        bus.tick = 1'b0;
    endtask

    task automatic expect_grant(input logic [3:0] mask, input logic [1:0] typ, input int at);
        grant_t g;
        g.mask = mask;
        g.typ  = typ;
        g.at   = 32'(at);
        grant_q.push_back(g);
    endtask

    // Monitor: compare every presented grant / pulse against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.canSpawn != 4'b0000) begin
                if (grant_q.size() == 0) begin
                    check("unexpected_grant", 32'(bus.canSpawn), 32'h0);
                end else begin
                    mon_g = grant_q.pop_front();
                    check("grant_mask", 32'(bus.canSpawn), 32'(mon_g.mask));
                    check("grant_type", 32'(bus.spawnType), 32'(mon_g.typ));
                    check("grant_cycle", 32'(cyc), mon_g.at);
                end
            end
            if (bus.damageSCEN) begin
                if (dmg_q.size() == 0) begin
                    check("unexpected_damage", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    mon_c = dmg_q.pop_front();
                    check("damage_cycle", 32'(cyc), 32'(mon_c));
                end
            end
            if (bus.moveSCEN) begin
                if (mv_q.size() == 0) begin
                    check("unexpected_move", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    mon_c = mv_q.pop_front();
                    check("move_cycle", 32'(cyc), 32'(mon_c));
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.tick        = 1'b0;
        bus.spawnPeriod = 8'd2;
        bus.slotDead    = 4'b0000;
        step(3);
        check("rst_canSpawn", 32'(bus.canSpawn), 32'h0);
        check("rst_spawnType", 32'(bus.spawnType), 32'h0);
        check("rst_damage", 32'(bus.damageSCEN), 32'h0);
        check("rst_move", 32'(bus.moveSCEN), 32'h0);
        check("rst_activeCount", 32'(bus.activeCount), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'h1);

        // Release with all slots dead, period 2: grants 0001/01, 0010/11, 0100/10.
        bus.slotDead = 4'b1111;
        bus.enable   = 1'b1;
        reset        = 1'b0;
        step(1);
        check("state_count", 32'(dut.state_q), 32'h2);
        expect_grant(4'b0001, 2'b01, cyc + 3);
        ticks(2);
        check("active_all_dead", 32'(bus.activeCount), 32'h0);
        step(5);
        expect_grant(4'b0010, 2'b11, cyc + 3);
        ticks(2);
        step(5);
        expect_grant(4'b0100, 2'b10, cyc + 3);
        ticks(2);
        step(5);

        // rrPtr=3, only slot 1 dead -> wraps to slot 1, rrPtr becomes 2.
        bus.slotDead = 4'b0010;
        expect_grant(4'b0010, 2'b01, cyc + 3);
        ticks(2);
        check("active_three", 32'(bus.activeCount), 32'h3);
        step(5);

        // rrPtr=2, only slot 0 dead -> wrap to slot 0, rrPtr becomes 1.
        bus.slotDead = 4'b0001;
        expect_grant(4'b0001, 2'b10, cyc + 3);
        ticks(2);
        step(5);

        // All dead again: search starts at 1, proving the pointer moved there.
        bus.slotDead = 4'b1111;
        expect_grant(4'b0010, 2'b01, cyc + 3);
        ticks(2);
        step(5);

        // No free slot when the count runs out: hold, then grant as slot 3 dies.
        bus.slotDead = 4'b0000;
        ticks(2);
        check("active_four", 32'(bus.activeCount), 32'h4);
        step(4);
        bus.slotDead = 4'b1000;
        expect_grant(4'b1000, 2'b11, cyc + 1);
        step(1);

        // spawnPeriod=0 behaves as 1: one tick then grant.
        bus.slotDead    = 4'b1111;
        bus.spawnPeriod = 8'd0;
        step(4);
        expect_grant(4'b0001, 2'b11, cyc + 2);
        ticks(1);
        step(1);

        // In-flight pulses complete after enable drops; SETTLE exits to IDLE.
        ticks(1);
        bus.enable = 1'b0;
        step(1);
        check("settle_to_idle", 32'(dut.state_q), 32'h1);
        ticks(2);
        bus.spawnPeriod = 8'd3;
        bus.enable      = 1'b1;
        step(1);
        check("idle_to_count", 32'(dut.state_q), 32'h2);
        bus.enable = 1'b0;
        step(1);
        check("count_to_idle", 32'(dut.state_q), 32'h1);

        // Reset during GRANT drops canSpawn at once.
        bus.spawnPeriod = 8'd1;
        bus.enable      = 1'b1;
        step(1);
        bus.tick = 1'b1;
        dmg_q.push_back(cyc + 1);
        step(1);
        bus.tick = 1'b0;
        step(1);
        check("pre_rst_canSpawn", 32'(bus.canSpawn), 32'h2);
        check("pre_rst_spawnType", 32'(bus.spawnType), 32'h3);
        bus.slotDead = 4'b0000;
        reset        = 1'b1;
        #1;
        check("midgrant_canSpawn", 32'(bus.canSpawn), 32'h0);
        check("midgrant_spawnType", 32'(bus.spawnType), 32'h0);
        check("midgrant_move", 32'(bus.moveSCEN), 32'h0);
        check("midgrant_active", 32'(bus.activeCount), 32'h0);
        step(2);
        bus.slotDead = 4'b1111;
        bus.enable   = 1'b0;
        reset        = 1'b0;
        step(1);
        check("post_rst_state", 32'(dut.state_q), 32'h1);

        // Seed and pointer restored: first grant is slot 0, type 01.
        bus.enable = 1'b1;
        step(1);
        expect_grant(4'b0001, 2'b01, cyc + 2);
        ticks(1);
        step(6);

        check("grants_drained", 32'(grant_q.size()), 32'h0);
        check("damage_drained", 32'(dmg_q.size()), 32'h0);
        check("move_drained", 32'(mv_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
